// File: rtl/matmul_result_reader_pkg.sv
// Shared types and constants for the matmul result reader: FSM states,
// element geometry and seven-segment digit patterns {g,f,e,d,c,b,a}.
package matmul_result_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHOW  = 2'd1,
      ST_BLANK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int ELEM_W   = 4;
   localparam int ELEM_CNT = 4;

   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;

   // True when a signed element lies within -2..+2.
   function automatic logic elem_in_range(input logic [ELEM_W-1:0] e);
      return ($signed(e) >= -4'sd2) && ($signed(e) <= 4'sd2);
   endfunction

endpackage

// File: rtl/matmul_result_reader_seg7.sv
// seg7_signed_decode: combinational 4-bit two's complement element to
// magnitude seven-segment pattern plus a separate sign flag.
module seg7_signed_decode
   import matmul_result_reader_pkg::*;
(
   input  logic [ELEM_W-1:0] i_elem,
   output logic [6:0]        o_seg,
   output logic              o_sign
);

   logic [ELEM_W-1:0] w_mag;

   // -8 negates back to 4'b1000, which reads as unsigned 8.
   assign w_mag  = i_elem[ELEM_W-1] ? (~i_elem + 4'd1) : i_elem;
   assign o_sign = i_elem[ELEM_W-1] && (i_elem != '0);

   always_comb begin
      o_seg = 7'h00;
      case (w_mag)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         default: o_seg = 7'h00;
      endcase
   end

endmodule

// File: rtl/matmul_result_reader.sv
// Sequences a captured 2x2 product onto a signed seven-segment display,
// one element per SHOW/BLANK pair. Optional range flag: RESULT_CHECK_EN.
module matmul_result_reader
   import matmul_result_reader_pkg::*;
#(
   parameter int DWELL_CYCLES = 1000,
   parameter int BLANK_CYCLES = 250
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic [15:0] res_in,
   input  logic        res_valid,
   output logic        res_ready,
   output logic [6:0]  seg_out,
   output logic        sign_out,
   output logic [1:0]  idx_out,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int MAX_C = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CNT_W = $clog2(MAX_C + 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [1:0]         r_idx;
   logic [15:0]        r_res;
   logic [6:0]         r_seg;
   logic               r_sign;
   logic               r_busy;
   logic               r_done;
   logic               w_capture;
   logic [1:0]         w_next_idx;
   logic [ELEM_W-1:0]  w_elem;
   logic [6:0]         w_seg;
   logic               w_sign;

   assign res_ready  = (r_state == ST_IDLE) && ena;
   assign w_capture  = res_valid && res_ready;
   assign w_next_idx = r_idx + 2'd1;

   // Decode the element about to be shown, so display outputs stay registered.
   always_comb begin
      w_elem = res_in[3:0];
      if (r_state != ST_IDLE) begin
         case (w_next_idx)
            2'd0: w_elem = r_res[3:0];
            2'd1: w_elem = r_res[7:4];
            2'd2: w_elem = r_res[11:8];
            2'd3: w_elem = r_res[15:12];
         endcase
      end
   end

   seg7_signed_decode u_dec (
      .i_elem (w_elem),
      .o_seg  (w_seg),
      .o_sign (w_sign)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_idx   <= 2'd0;
         r_res   <= 16'h0000;
         r_seg   <= 7'h00;
         r_sign  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (ena) begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_capture) begin
                  r_res   <= res_in;
                  r_idx   <= 2'd0;
                  r_cnt   <= '0;
                  r_seg   <= w_seg;
                  r_sign  <= w_sign;
                  r_busy  <= 1'b1;
                  r_state <= ST_SHOW;
               end
            end
            ST_SHOW: begin
               if (r_cnt == DWELL_LAST) begin
                  r_cnt   <= '0;
                  r_seg   <= 7'h00;
                  r_sign  <= 1'b0;
                  r_state <= ST_BLANK;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_BLANK: begin
               if (r_cnt == BLANK_LAST) begin
                  r_cnt <= '0;
                  if (r_idx == 2'd3) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_idx   <= w_next_idx;
                     r_seg   <= w_seg;
                     r_sign  <= w_sign;
                     r_state <= ST_SHOW;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign seg_out  = r_seg;
   assign sign_out = r_sign;
   assign idx_out  = r_idx;
   assign busy     = r_busy;
   assign done     = r_done;

`ifdef RESULT_CHECK_EN
   logic r_err;
   logic w_range_err;

   always_comb begin
      w_range_err = 1'b0;
      for (int i = 0; i < ELEM_CNT; i++)
         if (!elem_in_range(res_in[i*ELEM_W +: ELEM_W])) w_range_err = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         r_err <= 1'b0;
      else if (w_capture) r_err <= w_range_err;
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule

// File: doc/matmul_result_reader.md
MATMUL_RESULT_READER -- requirements
Module: matmul_result_reader

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 1000, number of cycles each element is displayed (min 1).
REQ-002 SHALL have parameter BLANK_CYCLES, default 250, number of blank cycles after each element (min 1).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ena  input  1  enable; low freezes all state and holds outputs.
REQ-006 SHALL have port res_in  input  16  packed 2x2 product {c22,c21,c12,c11}, 4-bit two's complement each, c11 at [3:0].
REQ-007 SHALL have port res_valid  input  1  res_in valid.
REQ-008 SHALL have port res_ready  output  1  block can accept a result.
REQ-009 SHALL have port seg_out  output  7  seven-segment pattern {g,f,e,d,c,b,a}, active-high.
REQ-010 SHALL have port sign_out  output  1  high when displayed element is negative.
REQ-011 SHALL have port idx_out  output  2  index of displayed element (0=c11,1=c12,2=c21,3=c22).
REQ-012 SHALL have port busy  output  1  high while a result is being sequenced.
REQ-013 SHALL have port done  output  1  one-cycle pulse at end of sequence.
REQ-014 SHALL have port err  output  1  range-check flag (see Configuration).

Function
REQ-015 SHALL implement states IDLE, SHOW, BLANK, DONE; res_ready = (state==IDLE) && ena.
REQ-016 SHALL capture res_in into an internal 16-bit register on a clock edge with res_valid && res_ready, and enter SHOW with idx=0 the next cycle; res_in changes are ignored outside IDLE.
REQ-017 SHOW SHALL last exactly DWELL_CYCLES enabled cycles, driving seg_out/sign_out for element idx, then enter BLANK.
REQ-018 BLANK SHALL last exactly BLANK_CYCLES enabled cycles with seg_out=0, sign_out=0; then idx<3 -> idx+1, SHOW; idx==3 -> DONE.
REQ-019 DONE SHALL last one cycle with done=1, then IDLE; capture-to-done latency = 4*(DWELL_CYCLES+BLANK_CYCLES)+1 edges.
REQ-020 busy SHALL be 1 in SHOW and BLANK, 0 in IDLE and DONE; idx_out holds last value in IDLE.
REQ-021 Magnitude SHALL be |element| in 0..8 (-8 -> 8); sign_out = element[3] && element!=0.
REQ-022 Encoding SHALL be 0=7'h3F,1=7'h06,2=7'h5B,3=7'h4F,4=7'h66,5=7'h6D,6=7'h7D,7=7'h07,8=7'h7F.
REQ-023 With ena=0 the dwell counter, idx, state and all outputs SHALL hold; res_ready=0; done, if high, stays high until the next enabled cycle.

Reset
REQ-024 rst_n low SHALL asynchronously force state=IDLE, idx=0, counter=0, captured register=0, seg_out=0, sign_out=0, idx_out=0, busy=0, done=0, err=0.
REQ-025 Reset asserted mid-sequence SHALL abort immediately with no done pulse; first capture permitted on the first enabled edge after release.

Configuration
REQ-026 With RESULT_CHECK_EN defined, err SHALL be set at capture if any element is outside -2..+2 and held until the next capture; sequencing proceeds unchanged.
REQ-027 Without RESULT_CHECK_EN, err SHALL be constant 0 and no check logic synthesized.

Structure
REQ-028 Shared package SHALL hold the state enumeration, element width (4), element count (4) and the 7-segment digit constants.
REQ-029 Sub-module seg7_signed_decode SHALL convert one 4-bit signed element to {sign_out, seg_out}, purely combinational.

Verification (DWELL_CYCLES=4, BLANK_CYCLES=2)
REQ-030 res_in=16'h21F0, valid 1 cycle -> seg 3F(+),06(-),06(+),5B(+) for 4 cycles each, 2 blank cycles between, done 25 edges after capture.
REQ-031 res_in=16'h8000 with RESULT_CHECK_EN -> err=1 after capture, c22 shows 7F sign 1; next capture 16'h0000 -> err=0.
REQ-032 res_valid held high with new res_in during SHOW -> res_ready=0, captured value unchanged; accepted only in IDLE after done.
REQ-033 ena low 5 cycles mid-SHOW -> outputs frozen, total latency extended by exactly 5 cycles.
REQ-034 rst_n pulsed low during BLANK idx=2 -> all outputs 0 immediately, no done, res_ready=1 after release.
